// File: rtl/score_text_pkg.sv
// Shared glyph constants, pipeline bundles and FSM state for
// the SCORE text overlay.
package score_text_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int ADDR_W  = 11;
  localparam int RGB_W   = 12;
  localparam int SLOT_W  = 7;
  localparam int ROW_W   = 4;

  typedef enum logic {
    IDLE,
    FLASH
  } flash_state_e;

  typedef struct packed {
    logic       in_box;
    logic [2:0] col;
    logic       video_on;
    logic       hsync;
    logic       vsync;
  } px_s1_t;

  typedef struct packed {
    logic text_on;
    logic video_on;
    logic hsync;
    logic vsync;
  } px_s2_t;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [SLOT_W-1:0] slot,
    input logic [ROW_W-1:0]  row
  );
    return {slot, row};
  endfunction

endpackage

// File: rtl/score_text_render_fsm.sv
// Frame-counted blink control: flashes the word for a fixed
// number of frames after each score event.
module score_flash_fsm
  import score_text_pkg::*;
#(
  parameter int FLASH_FRAMES = 120,
  parameter int BLINK_LOG2   = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync_in,
  input  logic score_evt,
  output logic show,
  output logic flash_active
);

  flash_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         vs_prev_q, vs_prev_d;
  logic         tick;

  localparam logic [7:0] LAST = 8'(FLASH_FRAMES - 1);

  always_comb begin
    vs_prev_d    = vsync_in;
    tick         = vs_prev_q & ~vsync_in;
    state_d      = state_q;
    cnt_d        = cnt_q;
    show         = 1'b1;
    flash_active = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (score_evt) begin
          state_d = FLASH;
          cnt_d   = '0;
        end
      end
      FLASH: begin
        show         = ~cnt_q[BLINK_LOG2];
        flash_active = 1'b1;
        // A new event restarts the flash even on a frame tick
        if (score_evt) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vs_prev_d;
    end
  end

endmodule

// File: rtl/score_text_render.sv
// Maps VGA coordinates onto the SCORE text box, reads the glyph
// ROM and emits a 2-cycle aligned text mask, colour and syncs.
module score_text_render
  import score_text_pkg::*;
#(
  parameter int          TEXT_X       = 288,
  parameter int          TEXT_Y       = 16,
  parameter int          SCALE_LOG2   = 1,
  parameter int          FIRST_SLOT   = 3,
  parameter int          NUM_CHARS    = 5,
  parameter int          FLASH_FRAMES = 120,
  parameter int          BLINK_LOG2   = 3,
  parameter logic [11:0] TEXT_RGB     = 12'hFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              score_evt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              text_on,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out,
  output logic              flash_active
);

  localparam int BOX_W = (NUM_CHARS * GLYPH_W) << SCALE_LOG2;
  localparam int BOX_H = GLYPH_H << SCALE_LOG2;
  localparam logic [9:0] X0 = 10'(TEXT_X);
  localparam logic [9:0] X1 = 10'(TEXT_X + BOX_W);
  localparam logic [9:0] Y0 = 10'(TEXT_Y);
  localparam logic [9:0] Y1 = 10'(TEXT_Y + BOX_H);

  logic              in_box;
  logic [9:0]        dx, dy;
  logic [SLOT_W-1:0] slot;
  logic [ROW_W-1:0]  row;
  logic              show;
  logic              pix_bit;
  px_s1_t            s1_q, s1_d;
  px_s2_t            s2_q, s2_d;

  score_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .BLINK_LOG2  (BLINK_LOG2)
  ) u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_in    (vsync_in),
    .score_evt   (score_evt),
    .show        (show),
    .flash_active(flash_active)
  );

  always_comb begin
    in_box = video_on
           & (pix_x >= X0) & (pix_x < X1)
           & (pix_y >= Y0) & (pix_y < Y1);
    dx   = pix_x - X0;
    dy   = pix_y - Y0;
    slot = 7'(FIRST_SLOT)
         + 7'(dx >> (3 + SCALE_LOG2));
    row  = 4'(dy >> SCALE_LOG2);
    // Outside the box the subtraction may wrap, so force addr 0
    rom_addr = in_box ? pack_addr(slot, row) : '0;

    s1_d.in_box   = in_box;
    s1_d.col      = 3'(dx >> SCALE_LOG2);
    s1_d.video_on = video_on;
    s1_d.hsync    = hsync_in;
    s1_d.vsync    = vsync_in;

    pix_bit = rom_data[3'd7 - s1_q.col];

    s2_d.text_on  = s1_q.in_box & pix_bit & show;
    s2_d.video_on = s1_q.video_on;
    s2_d.hsync    = s1_q.hsync;
    s2_d.vsync    = s1_q.vsync;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= '{in_box: 1'b0, col: 3'd0, video_on: 1'b0,
                hsync: 1'b1, vsync: 1'b1};
      s2_q <= '{text_on: 1'b0, video_on: 1'b0,
                hsync: 1'b1, vsync: 1'b1};
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign text_on      = s2_q.text_on;
  assign rgb_out      = s2_q.text_on ? TEXT_RGB : '0;
  assign hsync_out    = s2_q.hsync;
  assign vsync_out    = s2_q.vsync;
  assign video_on_out = s2_q.video_on;

endmodule

// File: tb/tb_score_text_render.sv
// Directed bench for score_text_render with a small glyph ROM
// model attached.
module tb_score_text_render;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        score_evt;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        video_on_out;
  logic        flash_active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_text_render dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .score_evt   (score_evt),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .text_on     (text_on),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .video_on_out(video_on_out),
    .flash_active(flash_active)
  );

  // 'S' rows are 0x7C, 'E' rows 0xFE; rows 14/15 blank
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a[3:0] >= 4'd14) return 8'h00;
    case (a[10:4])
      7'd3:    return 8'h7C;
      7'd7:    return 8'hFE;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input int x, input int y,
                     input logic vo,
                     input logic [10:0] a_exp,
                     input logic t_exp,
                     input string tag);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = vo;
    #1;
    chk({tag, "_addr"}, 32'(rom_addr), 32'(a_exp));
    step(2);
    chk({tag, "_text"}, 32'(text_on), 32'(t_exp));
    chk({tag, "_rgb"}, 32'(rgb_out),
        t_exp ? 32'hFFF : 32'h0);
  endtask

  task automatic tick();
    vsync_in = 1'b0;
    step(2);
    vsync_in = 1'b1;
    step(2);
  endtask

  task automatic evt();
    score_evt = 1'b1;
    step();
    score_evt = 1'b0;
  endtask

  task automatic hold_lit();
    pix_x    = 10'd290;
    pix_y    = 10'd20;
    video_on = 1'b1;
  endtask

  logic [7:0] hpat = 8'b1011_0010;
  logic [7:0] vpat = 8'b0110_1101;

  initial begin
    reset_n   = 1'b0;
    video_on  = 1'b0;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    pix_x     = '0;
    pix_y     = '0;
    score_evt = 1'b0;
    step(2);
    chk("rst_text", 32'(text_on), 0);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_vo", 32'(video_on_out), 0);
    chk("rst_hs", 32'(hsync_out), 1);
    chk("rst_vs", 32'(vsync_out), 1);
    chk("rst_flash", 32'(flash_active), 0);
    reset_n = 1'b1;

    pix(290, 20, 1'b1, 11'h032, 1'b1, "s_col1");
    pix(288, 20, 1'b1, 11'h032, 1'b0, "s_col0");
    pix(352, 20, 1'b1, 11'h072, 1'b1, "e_col0");
    pix(368, 20, 1'b1, 11'h000, 1'b0, "x_past");
    pix(367, 47, 1'b1, 11'h07F, 1'b0, "corner");
    pix(287, 20, 1'b1, 11'h000, 1'b0, "x_before");
    pix(300, 48, 1'b1, 11'h000, 1'b0, "y_past");
    pix(300, 47, 1'b1, 11'h03F, 1'b0, "y_last");
    pix(290, 20, 1'b0, 11'h000, 1'b0, "vid_off");
    chk("vid_off_out", 32'(video_on_out), 0);

    for (int k = 0; k < 10; k++) begin
      hsync_in = hpat[k % 8];
      vsync_in = vpat[k % 8];
      if (k >= 2) begin
        chk("hs_dly", 32'(hsync_out), 32'(hpat[(k-2) % 8]));
        chk("vs_dly", 32'(vsync_out), 32'(vpat[(k-2) % 8]));
      end
      step();
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    step(4);

    hold_lit();
    evt();
    chk("fl_start", 32'(flash_active), 1);
    step(2);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("blink_f%0d", k), 32'(text_on),
          (k < 8) ? 32'd1 : 32'd0);
      tick();
    end
    for (int k = 10; k < 119; k++) tick();
    chk("fl_119", 32'(flash_active), 1);
    tick();
    chk("fl_end", 32'(flash_active), 0);
    chk("fl_end_text", 32'(text_on), 1);

    evt();
    for (int k = 0; k < 49; k++) tick();
    vsync_in  = 1'b0;
    score_evt = 1'b1;
    step();
    score_evt = 1'b0;
    step();
    vsync_in = 1'b1;
    step(2);
    chk("rs_show", 32'(text_on), 1);
    for (int k = 0; k < 119; k++) tick();
    chk("rs_119", 32'(flash_active), 1);
    tick();
    chk("rs_end", 32'(flash_active), 0);

    evt();
    for (int k = 0; k < 9; k++) tick();
    chk("mid_dark", 32'(text_on), 0);
    reset_n = 1'b0;
    step();
    chk("mr_flash", 32'(flash_active), 0);
    chk("mr_text", 32'(text_on), 0);
    chk("mr_rgb", 32'(rgb_out), 0);
    chk("mr_hs", 32'(hsync_out), 1);
    chk("mr_vs", 32'(vsync_out), 1);
    chk("mr_vo", 32'(video_on_out), 0);
    reset_n = 1'b1;
    step(2);
    chk("mr_lit", 32'(text_on), 1);
    chk("mr_rgb_lit", 32'(rgb_out), 32'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
